// File: rtl/apb_master_arb_if.sv
// Bundle of requester-side and APB-side signals for apb_master_arb.
// "master" is the arbiter's view; "slave" is the view of everything around it.
interface apb_master_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [1:0]        iReq;
  logic              iWrite0;
  logic              iWrite1;
  logic [ADDR_W-1:0] iAddr0;
  logic [ADDR_W-1:0] iAddr1;
  logic [DATA_W-1:0] iWDat0;
  logic [DATA_W-1:0] iWDat1;
  logic [1:0]        oAck;
  logic [DATA_W-1:0] oRDat;
  logic              oErr;
  logic              oPSel;
  logic              oPEnable;
  logic              oPWrite;
  logic [ADDR_W-1:0] oPAddr;
  logic [DATA_W-1:0] oPWDat;
  logic [DATA_W-1:0] iPRDat;
  logic              iPReady;
  logic              iPSlvErr;

  modport master (
    input  iReq, iWrite0, iWrite1, iAddr0, iAddr1, iWDat0, iWDat1,
    input  iPRDat, iPReady, iPSlvErr,
    output oAck, oRDat, oErr, oPSel, oPEnable, oPWrite, oPAddr, oPWDat
  );

  modport slave (
    output iReq, iWrite0, iWrite1, iAddr0, iAddr1, iWDat0, iWDat1,
    output iPRDat, iPReady, iPSlvErr,
    input  oAck, oRDat, oErr, oPSel, oPEnable, oPWrite, oPAddr, oPWDat
  );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester APB4 master: round-robin arbitration, SETUP/ACCESS sequencing,
// PREADY wait states and a wait-state timeout that aborts hung transfers.
module apb_master_arb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                iPClk,
  input  logic                iPRstn,
  apb_master_arb_if.master    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT);
  localparam logic        TIMEOUT_EN = (TIMEOUT != 0);

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [15:0]       wait_cnt_inc;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdat_q, pwdat_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              err_q, err_d;
  logic [1:0]        elig;
  logic              win;
  logic              win_write;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_gnt_d   = last_gnt_q;
    wait_cnt_d   = wait_cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdat_d      = pwdat_q;
    ack_d        = 2'b00;
    rdat_d       = '0;
    err_d        = 1'b0;
    wait_cnt_inc = wait_cnt_q + 16'd1;

    // Masking with the current ack keeps a just-served requester out of its own ack cycle.
    elig      = bus.iReq & ~ack_q;
    win       = (elig == 2'b11) ? ~last_gnt_q : elig[1];
    win_write = win ? bus.iWrite1 : bus.iWrite0;

    case (state_q)
      ST_IDLE: begin
        if (elig != 2'b00) begin
          state_d    = ST_SETUP;
          gnt_d      = win;
          last_gnt_d = win;
          wait_cnt_d = '0;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = win_write;
          paddr_d    = win ? bus.iAddr1 : bus.iAddr0;
          if (win_write) pwdat_d = win ? bus.iWDat1 : bus.iWDat0;
          else           pwdat_d = '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (bus.iPReady) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = gnt_q ? 2'b10 : 2'b01;
          rdat_d    = pwrite_q ? '0 : bus.iPRDat;
          err_d     = bus.iPSlvErr;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (TIMEOUT_EN && (wait_cnt_inc == TIMEOUT_L)) begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            ack_d     = gnt_q ? 2'b10 : 2'b01;
            err_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iPClk or negedge iPRstn) begin
    if (!iPRstn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      wait_cnt_q <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdat_q    <= '0;
      ack_q      <= 2'b00;
      rdat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdat_q    <= pwdat_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      err_q      <= err_d;
    end
  end

  assign bus.oPSel    = psel_q;
  assign bus.oPEnable = penable_q;
  assign bus.oPWrite  = pwrite_q;
  assign bus.oPAddr   = paddr_q;
  assign bus.oPWDat   = pwdat_q;
  assign bus.oAck     = ack_q;
  assign bus.oRDat    = rdat_q;
  assign bus.oErr     = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_apb_master_arb;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .iPClk (clk),
    .iPRstn(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: a transfer in flight is described by its age in cycles since the grant.
  logic          m_busy;
  int            m_age;
  int            m_gnt;
  int            m_last;
  logic          m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdat;
  logic [1:0]    e_ack;
  logic [DW-1:0] e_rdat;
  logic          e_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_gnt = 0; m_last = 1;
    m_pwrite = 1'b0; m_paddr = '0; m_pwdat = '0;
    e_ack = 2'b00; e_rdat = '0; e_err = 1'b0;
  endtask

  // Advance the model across the coming clock edge using the inputs now on the bus.
  task automatic model_step();
    logic [1:0]    elig;
    logic [1:0]    n_ack;
    logic [DW-1:0] n_rdat;
    logic          n_err;
    int            w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n_ack = 2'b00; n_rdat = '0; n_err = 1'b0;
    if (!m_busy) begin
      elig = bus.iReq & ~e_ack;
      if (elig != 2'b00) begin
        if (elig == 2'b11) w = 1 - m_last;
        else               w = elig[1] ? 1 : 0;
        m_gnt = w; m_last = w; m_busy = 1'b1; m_age = 1;
        m_pwrite = (w == 1) ? bus.iWrite1 : bus.iWrite0;
        m_paddr  = (w == 1) ? bus.iAddr1  : bus.iAddr0;
        m_pwdat  = m_pwrite ? ((w == 1) ? bus.iWDat1 : bus.iWDat0) : '0;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else begin
      // m_age-1 is the number of ACCESS cycles completed at this edge
      if (bus.iPReady) begin
        m_busy = 1'b0;
        n_ack  = (m_gnt == 1) ? 2'b10 : 2'b01;
        n_rdat = m_pwrite ? '0 : bus.iPRDat;
        n_err  = bus.iPSlvErr;
      end else if (TO != 0 && (m_age - 1) == TO) begin
        m_busy = 1'b0;
        n_ack  = (m_gnt == 1) ? 2'b10 : 2'b01;
        n_err  = 1'b1;
      end else begin
        m_age++;
      end
    end
    e_ack = n_ack; e_rdat = n_rdat; e_err = n_err;
  endtask

  task automatic compare_all();
    chk("psel",    32'(bus.oPSel),    32'(m_busy));
    chk("penable", 32'(bus.oPEnable), 32'(m_busy && m_age >= 2));
    chk("pwrite",  32'(bus.oPWrite),  32'(m_pwrite));
    chk("paddr",   32'(bus.oPAddr),   32'(m_paddr));
    chk("pwdat",   32'(bus.oPWDat),   32'(m_pwdat));
    chk("ack",     32'(bus.oAck),     32'(e_ack));
    chk("rdat",    32'(bus.oRDat),    32'(e_rdat));
    chk("err",     32'(bus.oErr),     32'(e_err));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_fields(input int r);
    if (r == 0) begin
      bus.iWrite0 = 1'($urandom_range(0, 1));
      bus.iAddr0  = 8'($urandom);
      bus.iWDat0  = $urandom;
    end else begin
      bus.iWrite1 = 1'($urandom_range(0, 1));
      bus.iAddr1  = 8'($urandom);
      bus.iWDat1  = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int order[$];
    logic seen;
    logic prev_ack;
    int thresh;

    bus.iReq = 2'b00; bus.iWrite0 = 1'b0; bus.iWrite1 = 1'b0;
    bus.iAddr0 = '0; bus.iAddr1 = '0; bus.iWDat0 = '0; bus.iWDat1 = '0;
    bus.iPRDat = '0; bus.iPReady = 1'b0; bus.iPSlvErr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_psel", 32'(bus.oPSel), 32'd0);
    chk("rst_ack",  32'(bus.oAck),  32'd0);
    rst_n = 1'b1;

    // single write, zero wait
    bus.iReq = 2'b01; bus.iWrite0 = 1'b1; bus.iAddr0 = 8'h10; bus.iWDat0 = 32'hDEADBEEF;
    bus.iPReady = 1'b1;
    cycle();
    chk("wr_setup_psel", 32'(bus.oPSel), 32'd1);
    chk("wr_setup_pen",  32'(bus.oPEnable), 32'd0);
    chk("wr_paddr",      32'(bus.oPAddr), 32'h10);
    chk("wr_pwdat",      32'(bus.oPWDat), 32'hDEADBEEF);
    bus.iWDat0 = 32'h0BADF00D;
    cycle();
    chk("wr_access_pen", 32'(bus.oPEnable), 32'd1);
    chk("wr_pwdat_hold", 32'(bus.oPWDat), 32'hDEADBEEF);
    cycle();
    chk("wr_ack",  32'(bus.oAck), 32'h1);
    chk("wr_err",  32'(bus.oErr), 32'd0);
    chk("wr_psel_off", 32'(bus.oPSel), 32'd0);
    bus.iReq = 2'b00;
    cycle();
    chk("wr_ack_clear", 32'(bus.oAck), 32'd0);

    // read with 3 wait states
    bus.iReq = 2'b10; bus.iWrite1 = 1'b0; bus.iAddr1 = 8'h24; bus.iWDat1 = 32'hCAFEF00D;
    bus.iPReady = 1'b0; bus.iPRDat = 32'h0;
    cycle();
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (bus.oPEnable === 1'b1) acc++;
    end
    bus.iPReady = 1'b1; bus.iPRDat = 32'h12345678;
    cycle();
    chk("rd_access_cycles", 32'(acc), 32'd4);
    chk("rd_ack",  32'(bus.oAck),  32'h2);
    chk("rd_rdat", 32'(bus.oRDat), 32'h12345678);
    chk("rd_pwdat_zero", 32'(bus.oPWDat), 32'd0);
    bus.iReq = 2'b00;
    cycle();
    chk("rd_rdat_clear", 32'(bus.oRDat), 32'd0);

    // slave error, then a clean transfer
    bus.iReq = 2'b01; bus.iWrite0 = 1'b1; bus.iAddr0 = 8'h30; bus.iWDat0 = 32'h55;
    bus.iPSlvErr = 1'b1;
    repeat (3) cycle();
    chk("se_ack", 32'(bus.oAck), 32'h1);
    chk("se_err", 32'(bus.oErr), 32'd1);
    bus.iReq = 2'b00; bus.iPSlvErr = 1'b0;
    cycle();
    bus.iReq = 2'b01;
    repeat (3) cycle();
    chk("se_next_ack", 32'(bus.oAck), 32'h1);
    chk("se_next_err", 32'(bus.oErr), 32'd0);
    bus.iReq = 2'b00;
    cycle();

    // timeout
    bus.iReq = 2'b01; bus.iWrite0 = 1'b0; bus.iAddr0 = 8'h40;
    bus.iPReady = 1'b0; bus.iPRDat = 32'hFFFFFFFF;
    cycle();
    acc = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle();
      if (bus.oAck != 2'b00) seen = 1'b1;
      else if (bus.oPEnable === 1'b1) acc++;
    end
    chk("to_ack_seen", 32'(seen), 32'd1);
    chk("to_access_cycles", 32'(acc), 32'd16);
    chk("to_ack",  32'(bus.oAck),  32'h1);
    chk("to_err",  32'(bus.oErr),  32'd1);
    chk("to_rdat", 32'(bus.oRDat), 32'd0);
    chk("to_psel", 32'(bus.oPSel), 32'd0);
    bus.iReq = 2'b00; bus.iPReady = 1'b1;
    cycle();

    // reset mid-transfer
    bus.iReq = 2'b10; bus.iWrite1 = 1'b1; bus.iAddr1 = 8'h50; bus.iWDat1 = 32'h77;
    bus.iPReady = 1'b0;
    repeat (3) cycle();
    chk("mid_in_access", 32'(bus.oPEnable), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_psel",  32'(bus.oPSel),    32'd0);
    chk("mrst_pen",   32'(bus.oPEnable), 32'd0);
    chk("mrst_paddr", 32'(bus.oPAddr),   32'd0);
    chk("mrst_pwdat", 32'(bus.oPWDat),   32'd0);
    chk("mrst_pwr",   32'(bus.oPWrite),  32'd0);
    chk("mrst_ack",   32'(bus.oAck),     32'd0);
    repeat (2) begin
      cycle();
      chk("mrst_no_ack", 32'(bus.oAck), 32'd0);
    end
    bus.iReq = 2'b11; bus.iWrite0 = 1'b0; bus.iWrite1 = 1'b1; bus.iPReady = 1'b1;
    rst_n = 1'b1;

    // round-robin under contention; each requester drops only in its own ack cycle
    prev_ack = 1'b0;
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      cycle();
      if (prev_ack) chk("rr_next_setup", 32'(bus.oPSel), 32'd1);
      prev_ack = (bus.oAck != 2'b00);
      if (bus.oAck == 2'b01) order.push_back(0);
      if (bus.oAck == 2'b10) order.push_back(1);
      bus.iReq = ~bus.oAck;
    end
    chk("rr_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("rst_first_grant", 32'(order[0]), 32'd0);
      chk("rr_order1", 32'(order[1]), 32'd1);
      chk("rr_order2", 32'(order[2]), 32'd0);
      chk("rr_order3", 32'(order[3]), 32'd1);
    end
    bus.iReq = 2'b00;
    repeat (4) cycle();

    // randomized traffic
    thresh = 80;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: thresh = 80;
          1: thresh = 40;
          default: thresh = 2;
        endcase
      end
      for (int r = 0; r < 2; r++) begin
        if (bus.iReq[r]) begin
          if (e_ack[r]) begin
            if ($urandom_range(0, 1) == 0) bus.iReq[r] = 1'b0;
            else set_fields(r);
          end else if ($urandom_range(0, 3) == 0) begin
            set_fields(r);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          bus.iReq[r] = 1'b1;
          set_fields(r);
        end
      end
      bus.iPReady  = ($urandom_range(0, 99) < thresh);
      bus.iPSlvErr = ($urandom_range(0, 4) == 0);
      bus.iPRDat   = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
